// File: rtl/ip_ram_arbiter.sv
// ip_ram_arbiter
//
// Shares one external RAM read port among three cartridge IP requesters
// (e.g. KanjiROM, MegaROM mapper, sound-ROM reader). Each requester gets its
// own private copy of the read interface. Rising edges of reqN_rd are captured
// as pending requests. Requests are granted round-robin (0 -> 1 -> 2 -> 0).
// The arbiter runs the RAM handshake and returns the data to the owner only.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   reqN_rd        read request from requester N (rising edge sampled)
//   reqN_address   22-bit byte address, valid in the cycle reqN_rd rises
//   reqN_busy      requester N has a pending or in-flight read
//   reqN_rdata     read data for requester N, held until its next completion
//   reqN_rdata_en  one-cycle strobe marking reqN_rdata valid
//   ram_rd         read request to the RAM controller
//   ram_busy       RAM controller cannot accept; accept = ram_rd & ~ram_busy
//   ram_address    RAM address
//   ram_rdata      RAM read data
//   ram_rdata_en   one-cycle strobe marking ram_rdata valid
//
// Optional feature (macro IP_RAM_ARBITER_TIMEOUT_EN):
//   When defined, a WAIT-state watchdog completes a transaction with data
//   8'hFF after TIMEOUT_CYCLES cycles with no ram_rdata_en. When undefined,
//   WAIT is held until ram_rdata_en arrives.

module ip_ram_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_rd,
  input  logic [21:0] req0_address,
  output logic        req0_busy,
  output logic [7:0]  req0_rdata,
  output logic        req0_rdata_en,

  input  logic        req1_rd,
  input  logic [21:0] req1_address,
  output logic        req1_busy,
  output logic [7:0]  req1_rdata,
  output logic        req1_rdata_en,

  input  logic        req2_rd,
  input  logic [21:0] req2_address,
  output logic        req2_busy,
  output logic [7:0]  req2_rdata,
  output logic        req2_rdata_en,

  output logic        ram_rd,
  input  logic        ram_busy,
  output logic [21:0] ram_address,
  input  logic [7:0]  ram_rdata,
  input  logic        ram_rdata_en
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t              state, state_next;

  logic [NUM_REQ-1:0]  rd_in;
  logic [NUM_REQ-1:0]  ff_rd_d;
  logic [NUM_REQ-1:0]  rise;
  logic [NUM_REQ-1:0]  pending;
  logic [21:0]         addr_in [NUM_REQ];
  logic [21:0]         addr_q  [NUM_REQ];
  logic [7:0]          rdata_q [NUM_REQ];
  logic [NUM_REQ-1:0]  rdata_en_q;

  // last_grant doubles as the owner of the transaction in flight
  logic [1:0]          last_grant, last_grant_next;
  logic                ram_rd_next;
  logic [21:0]         ram_address_next;

  logic                grant_valid;
  logic [1:0]          grant_idx;
  logic                complete;
  logic [7:0]          complete_data;

`ifdef IP_RAM_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          wait_cnt, wait_cnt_next;
`else
  logic                unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  assign rd_in      = {req2_rd, req1_rd, req0_rd};
  assign addr_in[0] = req0_address;
  assign addr_in[1] = req1_address;
  assign addr_in[2] = req2_address;
  assign rise       = rd_in & ~ff_rd_d;

  assign req0_busy     = pending[0];
  assign req1_busy     = pending[1];
  assign req2_busy     = pending[2];
  assign req0_rdata    = rdata_q[0];
  assign req1_rdata    = rdata_q[1];
  assign req2_rdata    = rdata_q[2];
  assign req0_rdata_en = rdata_en_q[0];
  assign req1_rdata_en = rdata_en_q[1];
  assign req2_rdata_en = rdata_en_q[2];

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin pick: scan starting just after the last granted requester
  always_comb begin
    logic [1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = last_grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_next(cand);
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic for the RAM handshake
  always_comb begin
    state_next       = state;
    ram_rd_next      = ram_rd;
    ram_address_next = ram_address;
    last_grant_next  = last_grant;
    complete         = 1'b0;
    complete_data    = ram_rdata;
`ifdef IP_RAM_ARBITER_TIMEOUT_EN
    wait_cnt_next    = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (grant_valid) begin
          ram_rd_next      = 1'b1;
          ram_address_next = addr_q[grant_idx];
          last_grant_next  = grant_idx;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        if (!ram_busy) begin
          ram_rd_next = 1'b0;
          state_next  = WAIT;
`ifdef IP_RAM_ARBITER_TIMEOUT_EN
          wait_cnt_next = 8'd0;
`endif
        end
      end
      WAIT: begin
        // Real data beats the watchdog when both land in the same cycle
        if (ram_rdata_en) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
`ifdef IP_RAM_ARBITER_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          complete      = 1'b1;
          complete_data = 8'hFF;
          state_next    = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state and RAM-side output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 2'd2;
      ram_rd      <= 1'b0;
      ram_address <= 22'd0;
`ifdef IP_RAM_ARBITER_TIMEOUT_EN
      wait_cnt    <= 8'd0;
`endif
    end else begin
      state       <= state_next;
      last_grant  <= last_grant_next;
      ram_rd      <= ram_rd_next;
      ram_address <= ram_address_next;
`ifdef IP_RAM_ARBITER_TIMEOUT_EN
      wait_cnt    <= wait_cnt_next;
`endif
    end
  end

  // Request capture: an edge is only taken when nothing is pending, so a
  // re-request before completion is dropped and the latched address kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_rd_d <= '0;
      pending <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        addr_q[i] <= 22'd0;
      end
    end else begin
      ff_rd_d <= rd_in;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (complete && (last_grant == 2'(i))) begin
          pending[i] <= 1'b0;
        end else if (rise[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          addr_q[i]  <= addr_in[i];
        end
      end
    end
  end

  // Requester-side data return, routed to the owner only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_en_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rdata_q[i] <= 8'd0;
      end
    end else begin
      rdata_en_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (complete && (last_grant == 2'(i))) begin
          rdata_en_q[i] <= 1'b1;
          rdata_q[i]    <= complete_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// tb_ip_ram_arbiter
//
// Self-checking bench for ip_ram_arbiter. Directed steps cover the single
// read, round-robin order, busy stall, dropped re-request, reset mid-WAIT and
// (with IP_RAM_ARBITER_TIMEOUT_EN) the watchdog. A randomized phase drives
// random requests, busy and RAM latency, and checks against a transaction-
// level reference model: pending set per requester, round-robin grant order,
// and per-owner returned data.

module tb_ip_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_rd;
  logic [21:0] req_addr  [3];
  logic [2:0]  req_busy;
  logic [7:0]  req_rdata [3];
  logic [2:0]  req_en;
  logic        ram_rd;
  logic        ram_busy;
  logic [21:0] ram_address;
  logic [7:0]  ram_rdata;
  logic        ram_rdata_en;

  int total = 0;
  int bad   = 0;

  ip_ram_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req0_rd       (req_rd[0]),
    .req0_address  (req_addr[0]),
    .req0_busy     (req_busy[0]),
    .req0_rdata    (req_rdata[0]),
    .req0_rdata_en (req_en[0]),
    .req1_rd       (req_rd[1]),
    .req1_address  (req_addr[1]),
    .req1_busy     (req_busy[1]),
    .req1_rdata    (req_rdata[1]),
    .req1_rdata_en (req_en[1]),
    .req2_rd       (req_rd[2]),
    .req2_address  (req_addr[2]),
    .req2_busy     (req_busy[2]),
    .req2_rdata    (req_rdata[2]),
    .req2_rdata_en (req_en[2]),
    .ram_rd        (ram_rd),
    .ram_busy      (ram_busy),
    .ram_address   (ram_address),
    .ram_rdata     (ram_rdata),
    .ram_rdata_en  (ram_rdata_en)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] rd, input logic busy,
                               input logic en, input logic [7:0] data);
    req_rd       = rd;
    ram_busy     = busy;
    ram_rdata_en = en;
    ram_rdata    = data;
  endtask

  task automatic doReset();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) req_addr[i] = 22'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait (bounded) for ram_rd, check the address, accept at once, return data
  task automatic ram_txn(input string tag, input logic [21:0] exp_addr,
                         input logic [7:0] data, input int owner);
    int n;
    n = 0;
    while (ram_rd !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checkOutput({tag, " ram_rd"}, 32'(ram_rd), 32'd1);
    checkOutput({tag, " ram_address"}, 32'(ram_address), 32'(exp_addr));
    step();
    checkOutput({tag, " ram_rd drop"}, 32'(ram_rd), 32'd0);
    applyStimulus(3'b000, 1'b0, 1'b1, data);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    checkOutput({tag, " rdata_en"}, 32'(req_en), 32'(3'b001 << owner));
    checkOutput({tag, " rdata"}, 32'(req_rdata[owner]), 32'(data));
    checkOutput({tag, " busy clear"}, 32'(req_busy[owner]), 32'd0);
  endtask

  function automatic int rr_pick(input int last, input logic [2:0] pend);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (pend[idx]) return idx;
    end
    return 3;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  m_pend, m_prev, pend_pre, exp_en, rd;
    logic [21:0] m_addr [3];
    logic [7:0]  m_rdata [3];
    logic [21:0] addr_now;
    logic [7:0]  data;
    logic        rd_now, busy, en;
    bit          outstanding, out_pre, accept;
    int          m_last, m_owner, lat_cnt, g, captures, completions, early;

    // Reset state
    doReset();
    checkOutput("reset ram_rd", 32'(ram_rd), 32'd0);
    checkOutput("reset ram_address", 32'(ram_address), 32'd0);
    checkOutput("reset busy", 32'(req_busy), 32'd0);
    checkOutput("reset rdata_en", 32'(req_en), 32'd0);
    checkOutput("reset rdata0", 32'(req_rdata[0]), 32'd0);

    // Single read, RAM returns 3 cycles after accept
    req_addr[0] = 22'h300123;
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("t1 busy", 32'(req_busy), 32'b001);
    checkOutput("t1 ram_rd early", 32'(ram_rd), 32'd0);
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("t1 ram_rd", 32'(ram_rd), 32'd1);
    checkOutput("t1 ram_address", 32'(ram_address), 32'h300123);
    step();
    checkOutput("t1 ram_rd one cycle", 32'(ram_rd), 32'd0);
    step();
    step();
    applyStimulus(3'b000, 1'b0, 1'b1, 8'h5A);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    checkOutput("t1 rdata_en", 32'(req_en), 32'b001);
    checkOutput("t1 rdata0", 32'(req_rdata[0]), 32'h5A);
    checkOutput("t1 busy clear", 32'(req_busy), 32'd0);
    checkOutput("t1 rdata1", 32'(req_rdata[1]), 32'd0);
    checkOutput("t1 rdata2", 32'(req_rdata[2]), 32'd0);
    step();
    checkOutput("t1 rdata_en off", 32'(req_en), 32'd0);
    checkOutput("t1 rdata0 held", 32'(req_rdata[0]), 32'h5A);

    // Round-robin from reset, simultaneous edges on all three
    doReset();
    req_addr[0] = 22'h10;
    req_addr[1] = 22'h20;
    req_addr[2] = 22'h30;
    applyStimulus(3'b111, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    checkOutput("t2 busy all", 32'(req_busy), 32'b111);
    ram_txn("t2 r0", 22'h10, 8'hA0, 0);
    ram_txn("t2 r1", 22'h20, 8'hB0, 1);
    ram_txn("t2 r2", 22'h30, 8'hC0, 2);
    checkOutput("t2 rdata0 kept", 32'(req_rdata[0]), 32'hA0);
    req_addr[0] = 22'h40;
    req_addr[2] = 22'h50;
    applyStimulus(3'b101, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    ram_txn("t2 r0b", 22'h40, 8'hA1, 0);
    ram_txn("t2 r2b", 22'h50, 8'hC1, 2);
    checkOutput("t2 rdata1 kept", 32'(req_rdata[1]), 32'hB0);

    // Busy stall: 5 busy cycles keep ram_rd and ram_address for 6 cycles
    req_addr[1] = 22'h01234;
    applyStimulus(3'b010, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("t3 ram_rd rise", 32'(ram_rd), 32'd1);
    applyStimulus(3'b000, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("t3 hold ram_rd", 32'(ram_rd), 32'd1);
      checkOutput("t3 hold address", 32'(ram_address), 32'h01234);
    end
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("t3 ram_rd drop", 32'(ram_rd), 32'd0);
    applyStimulus(3'b000, 1'b0, 1'b1, 8'h77);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    checkOutput("t3 rdata_en", 32'(req_en), 32'b010);
    checkOutput("t3 rdata1", 32'(req_rdata[1]), 32'h77);

    // Dropped re-request while pending
    req_addr[1] = 22'h111;
    applyStimulus(3'b010, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("t4 ram_rd", 32'(ram_rd), 32'd1);
    checkOutput("t4 ram_address", 32'(ram_address), 32'h111);
    req_addr[1] = 22'h222;
    applyStimulus(3'b010, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    checkOutput("t4 ram_rd drop", 32'(ram_rd), 32'd0);
    checkOutput("t4 busy", 32'(req_busy), 32'b010);
    step();
    applyStimulus(3'b000, 1'b0, 1'b1, 8'h88);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    checkOutput("t4 rdata_en", 32'(req_en), 32'b010);
    checkOutput("t4 rdata1", 32'(req_rdata[1]), 32'h88);
    checkOutput("t4 busy clear", 32'(req_busy), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput("t4 no second ram_rd", 32'(ram_rd), 32'd0);
      checkOutput("t4 no second rdata_en", 32'(req_en), 32'd0);
    end

    // Reset in the middle of WAIT; a late RAM strobe must be ignored
    req_addr[0] = 22'h0F00F;
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    checkOutput("t5 reset ram_rd", 32'(ram_rd), 32'd0);
    checkOutput("t5 reset ram_address", 32'(ram_address), 32'd0);
    checkOutput("t5 reset busy", 32'(req_busy), 32'd0);
    checkOutput("t5 reset rdata1", 32'(req_rdata[1]), 32'd0);
    step();
    reset = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b1, 8'h99);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    checkOutput("t5 stray strobe rdata_en", 32'(req_en), 32'd0);
    checkOutput("t5 stray strobe busy", 32'(req_busy), 32'd0);
    checkOutput("t5 stray strobe rdata0", 32'(req_rdata[0]), 32'd0);
    step();
    checkOutput("t5 idle ram_rd", 32'(ram_rd), 32'd0);
    req_addr[2] = 22'h2AAAAA;
    applyStimulus(3'b100, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    ram_txn("t5 r2", 22'h2AAAAA, 8'h3C, 2);

`ifdef IP_RAM_ARBITER_TIMEOUT_EN
    // Watchdog: no RAM strobe ever, completion after 255 WAIT cycles
    doReset();
    req_addr[0] = 22'h0ABCDE;
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("t6 ram_rd", 32'(ram_rd), 32'd1);
    step();
    checkOutput("t6 ram_rd drop", 32'(ram_rd), 32'd0);
    early = 0;
    for (int k = 1; k < 255; k++) begin
      step();
      if (req_en !== 3'b000) early++;
    end
    checkOutput("t6 no early rdata_en", 32'(early), 32'd0);
    step();
    checkOutput("t6 timeout rdata_en", 32'(req_en), 32'b001);
    checkOutput("t6 timeout rdata", 32'(req_rdata[0]), 32'hFF);
    checkOutput("t6 timeout busy", 32'(req_busy), 32'd0);
    step();
    checkOutput("t6 rdata_en off", 32'(req_en), 32'd0);
    req_addr[0] = 22'h12;
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(3'b000, 1'b0, 1'b0, 8'h00);
    ram_txn("t6 after", 22'h12, 8'h21, 0);
`endif

    // Randomized traffic against the transaction-level model
    doReset();
    m_pend      = 3'b000;
    m_prev      = 3'b000;
    m_last      = 2;
    m_owner     = 0;
    outstanding = 1'b0;
    lat_cnt     = 0;
    captures    = 0;
    completions = 0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i]  = 22'd0;
      m_rdata[i] = 8'd0;
    end
    for (int cyc = 0; cyc < 2500; cyc++) begin
      rd = (cyc < 2400) ? 3'($urandom_range(0, 7)) : 3'b000;
      for (int i = 0; i < 3; i++) req_addr[i] = 22'($urandom());
      busy = ($urandom_range(0, 2) == 0);
      data = 8'($urandom());
      en   = 1'b0;
      if (outstanding) begin
        if (lat_cnt == 0) en = 1'b1;
        else lat_cnt--;
      end else if ($urandom_range(0, 9) == 0) begin
        en = 1'b1;
      end
      applyStimulus(rd, busy, en, data);

      rd_now   = ram_rd;
      addr_now = ram_address;
      pend_pre = m_pend;
      out_pre  = outstanding;
      accept   = rd_now && !busy;
      exp_en   = 3'b000;

      for (int i = 0; i < 3; i++) begin
        if (rd[i] && !m_prev[i] && !pend_pre[i]) begin
          m_pend[i] = 1'b1;
          m_addr[i] = req_addr[i];
          captures++;
        end
      end
      m_prev = rd;
      if (outstanding && en) begin
        m_pend[m_owner]  = 1'b0;
        m_rdata[m_owner] = data;
        exp_en[m_owner]  = 1'b1;
        outstanding      = 1'b0;
        completions++;
      end
      if (accept) begin
        outstanding = 1'b1;
        lat_cnt     = $urandom_range(0, 3);
      end

      step();

      if (!rd_now && ram_rd) begin
        g = rr_pick(m_last, pend_pre);
        checkOutput("rand grant while idle", 32'(out_pre), 32'd0);
        checkOutput("rand grant has pending", 32'(g < 3), 32'd1);
        if (g < 3) begin
          checkOutput("rand grant address", 32'(ram_address), 32'(m_addr[g]));
          m_last  = g;
          m_owner = g;
        end
      end
      if (rd_now && !accept) begin
        checkOutput("rand stall ram_rd", 32'(ram_rd), 32'd1);
        checkOutput("rand stall address", 32'(ram_address), 32'(addr_now));
      end
      if (accept) begin
        checkOutput("rand accept drop", 32'(ram_rd), 32'd0);
      end
      checkOutput("rand busy", 32'(req_busy), 32'(m_pend));
      checkOutput("rand rdata_en", 32'(req_en), 32'(exp_en));
      for (int i = 0; i < 3; i++) begin
        checkOutput("rand rdata", 32'(req_rdata[i]), 32'(m_rdata[i]));
      end
    end
    checkOutput("rand all served", 32'(completions), 32'(captures));
    checkOutput("rand drained busy", 32'(req_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
